pulse_debouncer: RTL and testbench

PULSE_DEBOUNCER -- requirements
Module: pulse_debouncer

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pulse_debouncer.sv | 116 +++++++++++
 tb/tb_pulse_debouncer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer family: FSM state encodings
// and a constant-width helper used to size counters from parameters.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    DISARM = 2'd3
  } db_state_t;

  // Ceiling log2, never narrower than one bit so a counter always exists.
  function automatic int clog2_w(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pulse_debouncer.sv
// Push-button debouncer producing a one-cycle strobe per accepted press.
// Define PULSE_DEBOUNCER_AUTO_REPEAT_EN to add periodic pulses while held.
module pulse_debouncer
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       pulse,
  output logic       level,
  output logic [1:0] state_o
);

  localparam int CNT_W = clog2_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > 65535 ||
      REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_param_check
    $error("pulse_debouncer: parameter out of range");
  end

  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn),
    .q     (s)
  );

`ifdef PULSE_DEBOUNCER_AUTO_REPEAT_EN
  localparam int REP_W = clog2_w(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep;
`endif

  // The stability counter only advances while s disagrees with level, and
  // the state is left as soon as it reaches its last value, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
`ifdef PULSE_DEBOUNCER_AUTO_REPEAT_EN
      rep   <= '0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= ARM;
            cnt   <= '0;
          end
        end
        ARM: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            level <= 1'b1;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state <= DISARM;
            cnt   <= '0;
          end
`ifdef PULSE_DEBOUNCER_AUTO_REPEAT_EN
          else if (rep == REP_LAST) begin
            pulse <= 1'b1;
            rep   <= '0;
          end else begin
            rep <= rep + 1'b1;
          end
`endif
        end
        DISARM: begin
          // Repeat counter is left untouched here so a glitchy release resumes it.
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
`ifdef PULSE_DEBOUNCER_AUTO_REPEAT_EN
            rep   <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pulse_debouncer.sv
// Self-checking bench for pulse_debouncer with DB_CYCLES=4, REPEAT_CYCLES=8,
// using directed scenarios, random bounce and a run-length reference model.
module tb_pulse_debouncer;

  localparam int DB  = 4;
  localparam int REP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       pulse;
  logic       level;
  logic [1:0] state_o;

  pulse_debouncer #(
    .DB_CYCLES     (DB),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .pulse   (pulse),
    .level   (level),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: btn reaches the debouncer two edges late; the accepted
  // level flips after DB+1 consecutive synchronized samples that disagree.
  logic dly0, dly1;
  logic m_level, m_pulse;
  int   m_run, m_rep;
  int   m_pulse_total = 0;
  int   dut_pulse_total = 0;
  logic prev_pulse = 1'b0;

  // Downstream decade counter driven by the strobe.
  logic [3:0] dec_count;
  int         dec_wraps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_count <= 4'd0;
      dec_wraps <= 0;
    end else if (pulse) begin
      if (dec_count == 4'd9) begin
        dec_count <= 4'd0;
        dec_wraps <= dec_wraps + 1;
      end else begin
        dec_count <= dec_count + 4'd1;
      end
    end
  end

  task automatic modelReset();
    dly0 = 1'b0; dly1 = 1'b0;
    m_level = 1'b0; m_pulse = 1'b0;
    m_run = 0; m_rep = 0;
  endtask

  task automatic modelEdge();
    logic s_now;
    logic held_high;
    if (!rst_n) begin
      modelReset();
      return;
    end
    s_now = dly1;
    dly1 = dly0;
    dly0 = btn;
    m_pulse = 1'b0;
    held_high = m_level && (m_run == 0);
    if (s_now != m_level) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_level = ~m_level;
        m_run = 0;
        m_rep = 0;
        if (m_level) m_pulse = 1'b1;
      end
    end else begin
      m_run = 0;
`ifdef PULSE_DEBOUNCER_AUTO_REPEAT_EN
      if (held_high) begin
        m_rep++;
        if (m_rep == REP) begin
          m_pulse = 1'b1;
          m_rep = 0;
        end
      end
`endif
    end
  endtask

  function automatic logic [1:0] modelState();
    if (m_level) return (m_run > 0) ? 2'd3 : 2'd2;
    return (m_run > 0) ? 2'd1 : 2'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive btn, let the edge happen, compare on the falling edge.
  task automatic applyStimulus(input logic b);
    btn = b;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("pulse", pulse, m_pulse);
    checkOutput("level", level, m_level);
    checkOutput("state", state_o, modelState());
    checkOutput("pulse_gap", prev_pulse & pulse, 1'b0);
    prev_pulse = pulse;
    if (pulse) dut_pulse_total++;
    if (m_pulse) m_pulse_total++;
  endtask

  task automatic doReset(input logic b);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_pulse", pulse, 1'b0);
    checkOutput("rst_level", level, 1'b0);
    checkOutput("rst_state", state_o, 2'd0);
    prev_pulse = 1'b0;
    applyStimulus(b);
    applyStimulus(b);
    rst_n = 1'b1;
  endtask

  task automatic holdLevel(input logic b, input int n);
    for (int i = 0; i < n; i++) applyStimulus(b);
  endtask

  initial begin
    int   first;
    int   p0;
    int   m0;
    int   exp_pulses[$];
    int   got_pulses[$];
    logic pat[9];
    logic val;
    int   len;

    modelReset();
    @(negedge clk);
    doReset(1'b0);
    holdLevel(1'b0, 3);
    $display("[TB] clean press");

    first = -1;
    p0 = dut_pulse_total;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1);
      if (pulse && first < 0) begin
        first = k;
        checkOutput("press_level", level, 1'b1);
      end
    end
    checkOutput("press_latency", first, 2 + DB);
`ifdef PULSE_DEBOUNCER_AUTO_REPEAT_EN
    checkOutput("press_count", dut_pulse_total - p0, 2);
`else
    checkOutput("press_count", dut_pulse_total - p0, 1);
`endif
    holdLevel(1'b0, 12);
    checkOutput("release_state", state_o, 2'd0);
    checkOutput("release_level", level, 1'b0);

    $display("[TB] bounce");
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    p0 = dut_pulse_total;
    for (int i = 0; i < 9; i++) applyStimulus(pat[i]);
    holdLevel(1'b1, 6);
    checkOutput("bounce_count", dut_pulse_total - p0, 1);
    holdLevel(1'b0, 12);

    $display("[TB] release glitch");
    holdLevel(1'b1, 9);
    checkOutput("glitch_held", state_o, 2'd2);
    p0 = dut_pulse_total;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("glitch_disarm", state_o, 2'd3);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("glitch_rehold", state_o, 2'd2);
    checkOutput("glitch_level", level, 1'b1);
    checkOutput("glitch_nopulse", dut_pulse_total - p0, 0);
    holdLevel(1'b0, 12);

    $display("[TB] reset in ARM");
    holdLevel(1'b1, 5);
    checkOutput("arm_state", state_o, 2'd1);
    doReset(1'b1);
    first = -1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1);
      if (pulse && first < 0) first = k;
    end
    checkOutput("reset_latency", first, 2 + DB);
    holdLevel(1'b0, 12);

    $display("[TB] long hold");
`ifdef PULSE_DEBOUNCER_AUTO_REPEAT_EN
    exp_pulses = '{6, 14, 22, 30, 38};
`else
    exp_pulses = '{6};
`endif
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1);
      if (pulse) got_pulses.push_back(k);
    end
    checkOutput("hold_count", got_pulses.size(), exp_pulses.size());
    for (int i = 0; i < exp_pulses.size() && i < got_pulses.size(); i++)
      checkOutput("hold_cycle", got_pulses[i], exp_pulses[i]);
    holdLevel(1'b0, 12);

    $display("[TB] decade chain");
    doReset(1'b0);
    m0 = m_pulse_total;
    p0 = dut_pulse_total;
    for (int n = 0; n < 10; n++) begin
      holdLevel(1'b1, 10);
      holdLevel(1'b0, 12);
    end
    checkOutput("chain_pulses", dut_pulse_total - p0, 10);
    checkOutput("chain_count", dec_count, (m_pulse_total - m0) % 10);
    checkOutput("chain_wraps", dec_wraps, (m_pulse_total - m0) / 10);

    $display("[TB] random bounce");
    for (int seg = 0; seg < 80; seg++) begin
      val = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      holdLevel(val, len);
      if (seg == 40) doReset(val);
    end
    holdLevel(1'b0, 12);
    checkOutput("total_pulses", dut_pulse_total, m_pulse_total);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
